pu_pipe: RTL and testbench
==========================

# pu_pipe

Parametrised, pipelined processing unit for the polar SC decoder datapath. It executes one decoder instruction per cycle: f/g LLR updates, leaf decisions (REP, SPC, RATE0, RATE1) and partial-sum combine. It generalises the combinational process unit in three ways: lane count and LLR width are parameters, there is a two-stage valid/ready pipeline with backpressure, and saturating arithmetic is applied. It sits between the instruction sequencer and the LLR/bit/combine memories; `mem_wr_en` selects the destination memory.

## Interface
- `P`, 8: f/g lanes; decision nodes cover 2P LLRs; power of 2, ≥2
- `Q`, 6: LLR width, signed two's complement
- `STW`, 3: width of the stage field
- `TAGW`, 4: width of the sequencer tag carried alongside each instruction
- `clk`  in  1  single clock; all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  instruction present
- `in_ready`  out  1  unit can accept
- `in_op`  in  4  opcode
- `in_stage`  in  STW  combine half-length exponent s
- `in_tag`  in  TAGW  sequencer tag
- `llr_in`  in  2·P·Q  lane i: a = `[i*Q+:Q]`, b = `[(P+i)*Q+:Q]`; decision LLR j = `[j*Q+:Q]`
- `funcg_bit_in`  in  P  partial sums u for g
- `bit_comb_left`, `bit_comb_right`  in  P each  combine operands
- `out_valid`  out  1  result present
- `out_ready`  in  1  consumer accepts
- `out_tag`  out  TAGW  tag of the result
- `mem_wr_en`  out  3  {llr, bit, comb}
- `llr_out`  out  P·Q  f/g results
- `bit_out`  out  2P  decision bits
- `bit_comb_out`  out  2P  combined bits
- `err_illegal`  out  1  sticky illegal-instruction flag
- `err_clr`  in  1  synchronous clear of `err_illegal`

## Operation
- Opcodes:
  - F=0001: `llr_out`[i] = sgn(a)^sgn(b) · min(|a|,|b|); |−2^(Q−1)| saturates to 2^(Q−1)−1.
  - G=0010: b + a if u[i]=0, else b − a; saturated to [−2^(Q−1), 2^(Q−1)−1].
  - G0R=0011: G with u forced to 0.
  - REP=0100: sum of all 2P LLRs at Q+log2(2P) bits, no overflow; all `bit_out` = (sum<0).
  - RATE0=0110: `bit_out` = 0.
  - RATE1=0111: `bit_out`[j] = (LLR j < 0).
  - SPC=0101: RATE1 hard decisions. If their XOR is 1, flip the bit with minimum |LLR|, lowest index on ties.
  - COMB=1000: L = 2^s. `bit_comb_out`[L−1:0] = left[L−1:0]^right[L−1:0]; [2L−1:L] = right[L−1:0]; bits above are 0.
  - COMB0R=1001: COMB with right forced to 0.
- `mem_wr_en`: F/G/G0R=100; REP/SPC/RATE0/RATE1=010; COMB/COMB0R=001.
- Outputs not produced by the current opcode are 0.
- Illegal instructions: any other opcode, or COMB/COMB0R with s > log2(P).
  - Flows through the pipeline with `mem_wr_en`=000 and zero data; `out_valid` is still asserted; tag is preserved.
  - Sets `err_illegal` on the cycle it is captured into stage 1.
  - Set has priority over a simultaneous `err_clr`.
- Pipeline:
  - Stage 1 registers op, stage, tag and operands.
  - Stage 2 computes and registers all outputs.
  - Data path is two entries deep; no internal FIFO.

## Timing
- Reset, asynchronous: `out_valid`=0, both stage valids 0, `mem_wr_en`=000, `llr_out`/`bit_out`/`bit_comb_out`/`out_tag`=0, `err_illegal`=0. `in_ready`=1 after reset.
- Reset mid-operation discards both in-flight instructions; nothing is output for them.
- Accept occurs on an edge with `in_valid`&`in_ready`. Its result is registered with `out_valid`=1 two edges later when not stalled: latency 2, throughput 1/cycle.
- Handshakes:
  - Output transfer occurs on an edge with `out_valid`&`out_ready`.
  - While `out_valid`&!`out_ready`, all outputs are held stable.
  - Stage 2 advances iff !`out_valid` | `out_ready`.
  - Stage 1 advances iff it is empty or stage 2 advances.
  - `in_ready` = stage-1 empty | stage-1 advancing. It is combinational from `out_ready` and never from `in_valid`.
- Full pipeline plus a stall: two instructions are held and `in_ready`=0. On the first `out_ready`=1 edge, one result leaves and one new instruction may enter on the same edge.
- `mem_wr_en` is non-zero only while `out_valid`=1.

## Test plan
- F: lane0 a=+5, b=−3 → −3; lane1 a=−32, b=−32 → +31; `mem_wr_en`=100 exactly 2 cycles after accept.
- G: u=1, a=10, b=−25 → −32 (saturated). G0R with u=1, a=10, b=−25 → −15.
- SPC: all LLRs +4 except j3=−1 and j7=+2 → `bit_out`=0 (bit3 flipped). REP: fifteen +1 and one −20 → `bit_out`=16'hFFFF, `mem_wr_en`=010.
- COMB: s=2, left=8'h0B, right=8'h06 → `bit_comb_out`=16'h006D. COMB with s=4 → illegal: `mem_wr_en`=000 and `err_illegal`=1 until `err_clr`.
- Backpressure: issue tags 1,2,3 back-to-back with `out_ready`=0 for 4 cycles → `in_ready` falls after 2 accepts, output holds tag 1 stable; on release, tags 1,2,3 emerge in order on consecutive cycles.
- Async `rst_n` pulse with two instructions in flight → all outputs 0 immediately, no stale result after release, `in_ready`=1.

Source files
------------

// File: rtl/pu_pipe.sv
// pu_pipe: two-stage valid/ready processing unit for the polar SC decoder.
// In: op/stage/tag + LLR/bit operands; out: results, mem_wr_en, err_illegal.
package pu_pipe_pkg;
  localparam logic [3:0] OP_F      = 4'b0001;
  localparam logic [3:0] OP_G      = 4'b0010;
  localparam logic [3:0] OP_G0R    = 4'b0011;
  localparam logic [3:0] OP_REP    = 4'b0100;
  localparam logic [3:0] OP_SPC    = 4'b0101;
  localparam logic [3:0] OP_RATE0  = 4'b0110;
  localparam logic [3:0] OP_RATE1  = 4'b0111;
  localparam logic [3:0] OP_COMB   = 4'b1000;
  localparam logic [3:0] OP_COMB0R = 4'b1001;
endpackage

module pu_pipe
  import pu_pipe_pkg::*;
#(
  parameter int P    = 8,
  parameter int Q    = 6,
  parameter int STW  = 3,
  parameter int TAGW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [STW-1:0]    in_stage,
  input  logic [TAGW-1:0]   in_tag,
  input  logic [2*P*Q-1:0]  llr_in,
  input  logic [P-1:0]      funcg_bit_in,
  input  logic [P-1:0]      bit_comb_left,
  input  logic [P-1:0]      bit_comb_right,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TAGW-1:0]   out_tag,
  output logic [2:0]        mem_wr_en,
  output logic [P*Q-1:0]    llr_out,
  output logic [2*P-1:0]    bit_out,
  output logic [2*P-1:0]    bit_comb_out,
  output logic              err_illegal,
  input  logic              err_clr
);

  localparam int N  = 2 * P;
  localparam int LP = $clog2(P);
  localparam int SW = Q + LP + 1;
  localparam int IW = $clog2(N);
  localparam logic [STW-1:0] SMAX = STW'(LP);

  function automatic logic legal(
    input logic [3:0]     op,
    input logic [STW-1:0] s
  );
    unique case (op)
      OP_F, OP_G, OP_G0R, OP_REP,
      OP_SPC, OP_RATE0, OP_RATE1: return 1'b1;
      OP_COMB, OP_COMB0R:         return s <= SMAX;
      default:                    return 1'b0;
    endcase
  endfunction

  // Unsigned magnitude; -2^(Q-1) maps to 2^(Q-1) exactly.
  function automatic logic [Q-1:0] abs_mag(input logic [Q-1:0] x);
    return x[Q-1] ? -x : x;
  endfunction

  function automatic logic [Q-1:0] f_op(input logic [Q-1:0] a, b);
    logic [Q-1:0] ma, mb, m;
    ma = abs_mag(a);
    mb = abs_mag(b);
    if (ma[Q-1]) ma = {1'b0, {(Q-1){1'b1}}};
    if (mb[Q-1]) mb = {1'b0, {(Q-1){1'b1}}};
    m = (ma < mb) ? ma : mb;
    return (a[Q-1] ^ b[Q-1]) ? -m : m;
  endfunction

  function automatic logic [Q-1:0] g_op(
    input logic [Q-1:0] a, b,
    input logic         u
  );
    logic signed [Q:0] sa, sb, s;
    sa = {a[Q-1], a};
    sb = {b[Q-1], b};
    s  = u ? sb - sa : sb + sa;
    if (s[Q] != s[Q-1])
      return s[Q] ? {1'b1, {(Q-1){1'b0}}}
                  : {1'b0, {(Q-1){1'b1}}};
    return s[Q-1:0];
  endfunction

  logic             s1_valid;
  logic [3:0]       s1_op;
  logic [STW-1:0]   s1_stage;
  logic [TAGW-1:0]  s1_tag;
  logic [N*Q-1:0]   s1_llr;
  logic [P-1:0]     s1_u, s1_l, s1_r;
  logic             adv1, adv2, acc;

  assign adv2     = !out_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = adv1;
  assign acc      = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_stage <= '0;
      s1_tag   <= '0;
      s1_llr   <= '0;
      s1_u     <= '0;
      s1_l     <= '0;
      s1_r     <= '0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op    <= in_op;
        s1_stage <= in_stage;
        s1_tag   <= in_tag;
        s1_llr   <= llr_in;
        s1_u     <= funcg_bit_in;
        s1_l     <= bit_comb_left;
        s1_r     <= bit_comb_right;
      end
    end
  end

  // Set wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_illegal <= 1'b0;
    else if (acc && !legal(in_op, in_stage))
      err_illegal <= 1'b1;
    else if (err_clr)
      err_illegal <= 1'b0;
  end

  logic signed [SW-1:0] rep_sum;
  logic [N-1:0]         hard, spc;
  logic [Q-1:0]         min_mag, mag;
  logic [IW-1:0]        min_idx;

  always_comb begin
    rep_sum = '0;
    hard    = '0;
    min_mag = '1;
    min_idx = '0;
    mag     = '0;
    for (int j = 0; j < N; j++) begin
      rep_sum = rep_sum + SW'($signed(s1_llr[j*Q+:Q]));
      hard[j] = s1_llr[j*Q+Q-1];
      mag     = abs_mag(s1_llr[j*Q+:Q]);
      if (mag < min_mag) begin
        min_mag = mag;
        min_idx = IW'(j);
      end
    end
    spc = hard ^ ({{(N-1){1'b0}}, ^hard} << min_idx);
  end

  int           clen;
  logic [N-1:0] cmask, cl, cr, comb_res;

  always_comb begin
    clen     = 1 << s1_stage;
    cmask    = ~({N{1'b1}} << clen);
    cl       = {{P{1'b0}}, s1_l};
    cr       = (s1_op == OP_COMB0R) ? '0 : {{P{1'b0}}, s1_r};
    comb_res = ((cl ^ cr) & cmask) | ((cr & cmask) << clen);
  end

  logic           ok, is_fg, is_dec, is_cmb;
  logic [2:0]     n_mem;
  logic [P*Q-1:0] n_llr;
  logic [N-1:0]   n_bit, n_comb;

  assign ok     = s1_valid && legal(s1_op, s1_stage);
  assign is_fg  = ok && (s1_op inside {OP_F, OP_G, OP_G0R});
  assign is_dec = ok && (s1_op inside {OP_REP, OP_SPC,
                                       OP_RATE0, OP_RATE1});
  assign is_cmb = ok && (s1_op inside {OP_COMB, OP_COMB0R});

  always_comb begin
    n_mem  = '0;
    n_llr  = '0;
    n_bit  = '0;
    n_comb = '0;
    unique case (1'b1)
      is_fg: begin
        n_mem = 3'b100;
        for (int i = 0; i < P; i++)
          n_llr[i*Q+:Q] = (s1_op == OP_F)
            ? f_op(s1_llr[i*Q+:Q], s1_llr[(P+i)*Q+:Q])
            : g_op(s1_llr[i*Q+:Q], s1_llr[(P+i)*Q+:Q],
                   (s1_op == OP_G) && s1_u[i]);
      end
      is_dec: begin
        n_mem = 3'b010;
        unique case (s1_op)
          OP_REP:   n_bit = {N{rep_sum[SW-1]}};
          OP_SPC:   n_bit = spc;
          OP_RATE1: n_bit = hard;
          default:  n_bit = '0;
        endcase
      end
      is_cmb: begin
        n_mem  = 3'b001;
        n_comb = comb_res;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_tag      <= '0;
      mem_wr_en    <= '0;
      llr_out      <= '0;
      bit_out      <= '0;
      bit_comb_out <= '0;
    end else if (adv2) begin
      out_valid    <= s1_valid;
      out_tag      <= s1_valid ? s1_tag : '0;
      mem_wr_en    <= n_mem;
      llr_out      <= n_llr;
      bit_out      <= n_bit;
      bit_comb_out <= n_comb;
    end
  end

endmodule

// File: tb/tb_pu_pipe.sv
// tb_pu_pipe: directed and randomized checks of pu_pipe
// against an integer reference model and an in-order scoreboard.
module tb_pu_pipe;

  localparam int P    = 8;
  localparam int Q    = 6;
  localparam int STW  = 3;
  localparam int TAGW = 4;
  localparam int N    = 2 * P;
  localparam int QMAX = (1 << (Q - 1)) - 1;
  localparam int QMIN = -(1 << (Q - 1));
  localparam int LP   = $clog2(P);

  localparam logic [3:0] OP_F      = 4'h1;
  localparam logic [3:0] OP_G      = 4'h2;
  localparam logic [3:0] OP_G0R    = 4'h3;
  localparam logic [3:0] OP_REP    = 4'h4;
  localparam logic [3:0] OP_SPC    = 4'h5;
  localparam logic [3:0] OP_RATE0  = 4'h6;
  localparam logic [3:0] OP_RATE1  = 4'h7;
  localparam logic [3:0] OP_COMB   = 4'h8;
  localparam logic [3:0] OP_COMB0R = 4'h9;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_op;
  logic [STW-1:0]    in_stage;
  logic [TAGW-1:0]   in_tag;
  logic [N*Q-1:0]    llr_in;
  logic [P-1:0]      funcg_bit_in;
  logic [P-1:0]      bit_comb_left;
  logic [P-1:0]      bit_comb_right;
  logic              out_valid;
  logic              out_ready;
  logic [TAGW-1:0]   out_tag;
  logic [2:0]        mem_wr_en;
  logic [P*Q-1:0]    llr_out;
  logic [N-1:0]      bit_out;
  logic [N-1:0]      bit_comb_out;
  logic              err_illegal;
  logic              err_clr;

  int vectors;
  int miscompares;

  pu_pipe #(.P(P), .Q(Q), .STW(STW), .TAGW(TAGW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_op          (in_op),
    .in_stage       (in_stage),
    .in_tag         (in_tag),
    .llr_in         (llr_in),
    .funcg_bit_in   (funcg_bit_in),
    .bit_comb_left  (bit_comb_left),
    .bit_comb_right (bit_comb_right),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_tag        (out_tag),
    .mem_wr_en      (mem_wr_en),
    .llr_out        (llr_out),
    .bit_out        (bit_out),
    .bit_comb_out   (bit_comb_out),
    .err_illegal    (err_illegal),
    .err_clr        (err_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct packed {
    logic [TAGW-1:0] tag;
    logic [2:0]      mem;
    logic [P*Q-1:0]  llr;
    logic [N-1:0]    bits;
    logic [N-1:0]    comb;
    int              acc_edge;
  } exp_t;

  function automatic int lane(input logic [N*Q-1:0] li, input int j);
    logic signed [Q-1:0] t;
    t = li[j*Q+:Q];
    return int'(t);
  endfunction

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  function automatic exp_t model(
    input logic [3:0]      op,
    input logic [STW-1:0]  st,
    input logic [TAGW-1:0] tag,
    input logic [N*Q-1:0]  li,
    input logic [P-1:0]    u,
    input logic [P-1:0]    cl,
    input logic [P-1:0]    cr
  );
    exp_t e;
    int a, b, ma, mb, r, sum, par, mi, mv, len;
    logic [P-1:0] rr;
    e     = '0;
    e.tag = tag;
    case (op)
      OP_F: begin
        e.mem = 3'b100;
        for (int i = 0; i < P; i++) begin
          a  = lane(li, i);
          b  = lane(li, P + i);
          ma = (iabs(a) > QMAX) ? QMAX : iabs(a);
          mb = (iabs(b) > QMAX) ? QMAX : iabs(b);
          r  = (ma < mb) ? ma : mb;
          if ((a < 0) != (b < 0)) r = -r;
          e.llr[i*Q+:Q] = Q'(r);
        end
      end
      OP_G, OP_G0R: begin
        e.mem = 3'b100;
        for (int i = 0; i < P; i++) begin
          a = lane(li, i);
          b = lane(li, P + i);
          r = (op == OP_G && u[i]) ? b - a : b + a;
          if (r > QMAX) r = QMAX;
          if (r < QMIN) r = QMIN;
          e.llr[i*Q+:Q] = Q'(r);
        end
      end
      OP_REP: begin
        e.mem = 3'b010;
        sum = 0;
        for (int j = 0; j < N; j++) sum += lane(li, j);
        if (sum < 0) e.bits = '1;
      end
      OP_RATE0: e.mem = 3'b010;
      OP_RATE1, OP_SPC: begin
        e.mem = 3'b010;
        par = 0;
        mi  = 0;
        mv  = 1 << 20;
        for (int j = 0; j < N; j++) begin
          a = lane(li, j);
          if (a < 0) begin
            e.bits[j] = 1'b1;
            par ^= 1;
          end
          if (iabs(a) < mv) begin
            mv = iabs(a);
            mi = j;
          end
        end
        if (op == OP_SPC && par == 1) e.bits[mi] = ~e.bits[mi];
      end
      OP_COMB, OP_COMB0R: begin
        if (int'(st) <= LP) begin
          e.mem = 3'b001;
          len = 1 << st;
          rr  = (op == OP_COMB0R) ? '0 : cr;
          for (int k = 0; k < N; k++) begin
            if (k < len)          e.comb[k] = cl[k] ^ rr[k];
            else if (k < 2 * len) e.comb[k] = rr[k - len];
          end
        end
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic drive(
    input logic [3:0]      op,
    input logic [STW-1:0]  st,
    input logic [TAGW-1:0] tag,
    input logic [N*Q-1:0]  li,
    input logic [P-1:0]    u,
    input logic [P-1:0]    cl,
    input logic [P-1:0]    cr
  );
    in_op          = op;
    in_stage       = st;
    in_tag         = tag;
    llr_in         = li;
    funcg_bit_in   = u;
    bit_comb_left  = cl;
    bit_comb_right = cr;
  endtask

  // Issue one instruction on an idle pipe; returns #1 after its result edge.
  task automatic send(
    input logic [3:0]      op,
    input logic [STW-1:0]  st,
    input logic [TAGW-1:0] tag,
    input logic [N*Q-1:0]  li,
    input logic [P-1:0]    u,
    input logic [P-1:0]    cl,
    input logic [P-1:0]    cr
  );
    drive(op, st, tag, li, u, cl, cr);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    vectors++;
    if ({out_valid, mem_wr_en, out_tag, err_illegal} !== '0 ||
        {llr_out, bit_out, bit_comb_out} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got v=%b mem=%b tag=%h err=%b",
               out_valid, mem_wr_en, out_tag, err_illegal);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready got rdy=%b v=%b want 1 0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_f();
    logic [N*Q-1:0] li;
    exp_t e;
    li = '0;
    li[0*Q+:Q]     = Q'(5);
    li[P*Q+:Q]     = Q'(-3);
    li[1*Q+:Q]     = Q'(-32);
    li[(P+1)*Q+:Q] = Q'(-32);
    e = model(OP_F, 0, 4'h5, li, '0, '0, '0);
    drive(OP_F, 0, 4'h5, li, '0, '0, '0);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || mem_wr_en !== 3'b000) begin
      miscompares++;
      $display("FAIL f_latency1 got v=%b mem=%b want 0 000",
               out_valid, mem_wr_en);
    end
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b1 || mem_wr_en !== 3'b100 || out_tag !== 4'h5) begin
      miscompares++;
      $display("FAIL f_latency2 got v=%b mem=%b tag=%h want 1 100 5",
               out_valid, mem_wr_en, out_tag);
    end
    vectors++;
    if (llr_out[0+:Q] !== 6'b111101 || llr_out[Q+:Q] !== 6'd31) begin
      miscompares++;
      $display("FAIL f_lanes got l0=%h l1=%h want 3d 1f",
               llr_out[0+:Q], llr_out[Q+:Q]);
    end
    vectors++;
    if (llr_out !== e.llr || bit_out !== '0 || bit_comb_out !== '0) begin
      miscompares++;
      $display("FAIL f_all got %h want %h", llr_out, e.llr);
    end
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b0 || mem_wr_en !== 3'b000) begin
      miscompares++;
      $display("FAIL f_drain got v=%b mem=%b want 0 000",
               out_valid, mem_wr_en);
    end
  endtask

  task automatic test_g();
    logic [N*Q-1:0] li;
    li = '0;
    li[0*Q+:Q] = Q'(10);
    li[P*Q+:Q] = Q'(-25);
    send(OP_G, 0, 4'h6, li, 8'h01, '0, '0);
    vectors++;
    if (llr_out[0+:Q] !== 6'b100000 || mem_wr_en !== 3'b100) begin
      miscompares++;
      $display("FAIL g_sat got l0=%h mem=%b want 20 100",
               llr_out[0+:Q], mem_wr_en);
    end
    send(OP_G0R, 0, 4'h7, li, 8'h01, '0, '0);
    vectors++;
    if (llr_out[0+:Q] !== 6'b110001 || out_tag !== 4'h7) begin
      miscompares++;
      $display("FAIL g0r got l0=%h tag=%h want 31 7",
               llr_out[0+:Q], out_tag);
    end
  endtask

  task automatic test_decisions();
    logic [N*Q-1:0] li;
    for (int j = 0; j < N; j++) li[j*Q+:Q] = Q'(4);
    li[3*Q+:Q] = Q'(-1);
    li[7*Q+:Q] = Q'(2);
    send(OP_SPC, 0, 4'h1, li, '0, '0, '0);
    vectors++;
    if (bit_out !== 16'h0000 || mem_wr_en !== 3'b010) begin
      miscompares++;
      $display("FAIL spc got bits=%h mem=%b want 0000 010",
               bit_out, mem_wr_en);
    end
    send(OP_RATE1, 0, 4'h2, li, '0, '0, '0);
    vectors++;
    if (bit_out !== 16'h0008 || mem_wr_en !== 3'b010) begin
      miscompares++;
      $display("FAIL rate1 got bits=%h mem=%b want 0008 010",
               bit_out, mem_wr_en);
    end
    for (int j = 0; j < N; j++) li[j*Q+:Q] = Q'(1);
    li[5*Q+:Q] = Q'(-20);
    send(OP_REP, 0, 4'h3, li, '0, '0, '0);
    vectors++;
    if (bit_out !== 16'hFFFF || mem_wr_en !== 3'b010 || llr_out !== '0) begin
      miscompares++;
      $display("FAIL rep got bits=%h mem=%b want ffff 010",
               bit_out, mem_wr_en);
    end
    send(OP_RATE0, 0, 4'h4, li, '1, '1, '1);
    vectors++;
    if (bit_out !== 16'h0000 || mem_wr_en !== 3'b010) begin
      miscompares++;
      $display("FAIL rate0 got bits=%h mem=%b want 0000 010",
               bit_out, mem_wr_en);
    end
  endtask

  task automatic test_comb();
    send(OP_COMB, 3'd2, 4'h9, '0, '0, 8'h0B, 8'h06);
    vectors++;
    if (bit_comb_out !== 16'h006D || mem_wr_en !== 3'b001) begin
      miscompares++;
      $display("FAIL comb got %h mem=%b want 006d 001",
               bit_comb_out, mem_wr_en);
    end
    send(OP_COMB0R, 3'd3, 4'hA, '0, '0, 8'hA5, 8'hFF);
    vectors++;
    if (bit_comb_out !== 16'h00A5 || mem_wr_en !== 3'b001) begin
      miscompares++;
      $display("FAIL comb0r got %h mem=%b want 00a5 001",
               bit_comb_out, mem_wr_en);
    end
    send(OP_COMB, 3'd4, 4'hB, '0, '0, 8'h0B, 8'h06);
    vectors++;
    if (out_valid !== 1'b1 || out_tag !== 4'hB || mem_wr_en !== 3'b000 ||
        bit_comb_out !== '0 || err_illegal !== 1'b1) begin
      miscompares++;
      $display("FAIL illegal got v=%b tag=%h mem=%b err=%b want 1 b 000 1",
               out_valid, out_tag, mem_wr_en, err_illegal);
    end
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (err_illegal !== 1'b1) begin
      miscompares++;
      $display("FAIL err_sticky got %b want 1", err_illegal);
    end
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    vectors++;
    if (err_illegal !== 1'b0) begin
      miscompares++;
      $display("FAIL err_clr got %b want 0", err_illegal);
    end
    drive(4'hF, 0, 4'hC, '0, '0, '0, '0);
    in_valid = 1'b1;
    err_clr  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    err_clr  = 1'b0;
    vectors++;
    if (err_illegal !== 1'b1) begin
      miscompares++;
      $display("FAIL err_set_prio got %b want 1", err_illegal);
    end
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b1 || mem_wr_en !== 3'b000 || out_tag !== 4'hC) begin
      miscompares++;
      $display("FAIL illegal_op got v=%b mem=%b tag=%h want 1 000 c",
               out_valid, mem_wr_en, out_tag);
    end
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
  endtask

  task automatic test_back_to_back();
    drive(OP_F, 0, 4'h1, '0, '0, '0, '0);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_tag = 4'h2;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_ready1 got %b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_tag = 4'h3;
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_tag !== 4'h1 ||
          mem_wr_en !== 3'b100) begin
        miscompares++;
        $display("FAIL bp_hold c=%0d got rdy=%b v=%b tag=%h want 0 1 1",
                 c, in_ready, out_valid, out_tag);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release_ready got %b want 1", in_ready);
    end
    for (int t = 1; t <= 3; t++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_tag !== TAGW'(t)) begin
        miscompares++;
        $display("FAIL bp_order got v=%b tag=%h want 1 %0d",
                 out_valid, out_tag, t);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_empty got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_async_reset();
    drive(OP_REP, 0, 4'h7, '1, '0, '0, '0);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_tag = 4'h8;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({out_valid, mem_wr_en, out_tag} !== '0 ||
        {llr_out, bit_out, bit_comb_out} !== '0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL async_rst got v=%b mem=%b tag=%h rdy=%b",
               out_valid, mem_wr_en, out_tag, in_ready);
    end
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b0 || mem_wr_en !== 3'b000) begin
        miscompares++;
        $display("FAIL async_stale c=%0d got v=%b mem=%b want 0 000",
                 c, out_valid, mem_wr_en);
      end
    end
  endtask

  task automatic test_random();
    exp_t           sb[$];
    exp_t           e;
    logic [N*Q-1:0] li;
    logic           exp_err, exp_ov, acc, xfer, drain;
    int             cyc, r;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    err_clr   = 1'b0;
    rst_n     = 1'b0;
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    cyc     = 0;
    exp_err = 1'b0;
    for (int it = 0; it < 800; it++) begin
      drain     = (it >= 780);
      in_valid  = !drain && ($urandom_range(0, 3) != 0);
      out_ready = drain || ($urandom_range(0, 2) != 0);
      err_clr   = !drain && ($urandom_range(0, 15) == 0);
      r = $urandom_range(0, 15);
      case (r)
        0, 1:    in_op = OP_F;
        2, 3:    in_op = OP_G;
        4:       in_op = OP_G0R;
        5:       in_op = OP_REP;
        6, 7:    in_op = OP_SPC;
        8:       in_op = OP_RATE0;
        9:       in_op = OP_RATE1;
        10, 11:  in_op = OP_COMB;
        12:      in_op = OP_COMB0R;
        default: in_op = 4'($urandom);
      endcase
      in_stage = STW'($urandom_range(0, 4));
      in_tag   = TAGW'(it);
      for (int j = 0; j < N; j++)
        li[j*Q+:Q] = ($urandom_range(0, 1) == 1)
          ? Q'($urandom_range(0, 63))
          : Q'(int'($urandom_range(0, 6)) - 3);
      llr_in         = li;
      funcg_bit_in   = P'($urandom);
      bit_comb_left  = P'($urandom);
      bit_comb_right = P'($urandom);
      @(negedge clk);
      exp_ov = (sb.size() > 0) && (sb[0].acc_edge + 1 <= cyc);
      vectors++;
      if (out_valid !== exp_ov) begin
        miscompares++;
        $display("FAIL rnd_valid it=%0d got %b want %b", it, out_valid, exp_ov);
      end
      vectors++;
      if (in_ready !== ((sb.size() < 2) || out_ready)) begin
        miscompares++;
        $display("FAIL rnd_ready it=%0d got %b depth=%0d ordy=%b",
                 it, in_ready, sb.size(), out_ready);
      end
      vectors++;
      if (exp_ov) begin
        if ({out_tag, mem_wr_en, llr_out, bit_out, bit_comb_out} !==
            {sb[0].tag, sb[0].mem, sb[0].llr, sb[0].bits, sb[0].comb}) begin
          miscompares++;
          $display("FAIL rnd_data it=%0d got %h/%b/%h/%h/%h want %h/%b/%h/%h/%h",
                   it, out_tag, mem_wr_en, llr_out, bit_out, bit_comb_out,
                   sb[0].tag, sb[0].mem, sb[0].llr, sb[0].bits, sb[0].comb);
        end
      end else if (mem_wr_en !== 3'b000) begin
        miscompares++;
        $display("FAIL rnd_idle_mem it=%0d got %b want 000", it, mem_wr_en);
      end
      acc  = in_valid && in_ready;
      xfer = out_valid && out_ready;
      e = model(in_op, in_stage, in_tag, llr_in, funcg_bit_in,
                bit_comb_left, bit_comb_right);
      e.acc_edge = cyc + 1;
      if (acc && e.mem == 3'b000) exp_err = 1'b1;
      else if (err_clr)          exp_err = 1'b0;
      if (xfer && sb.size() > 0) void'(sb.pop_front());
      if (acc) sb.push_back(e);
      @(posedge clk); #1;
      cyc++;
      vectors++;
      if (err_illegal !== exp_err) begin
        miscompares++;
        $display("FAIL rnd_err it=%0d got %b want %b", it, err_illegal, exp_err);
      end
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL rnd_drain got %0d pending want 0", sb.size());
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    err_clr     = 1'b0;
    drive('0, '0, '0, '0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_f();
    test_g();
    test_decisions();
    test_comb();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
